// File: rtl/dma_axi_arb.sv
// dma_axi_arb: two-port round-robin arbiter in front of a single DMA burst master.
// Optional burst watchdog enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_axi_arb #(
  parameter int DMA_DATA_W = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_0,
  input  logic [AXI_ADDR_W-1:0]   address_0,
  input  logic [DMA_DATA_W-1:0]   wdata_0,
  input  logic [DMA_DATA_W/8-1:0] wstrb_0,
  input  logic [AXI_LEN_W-1:0]    dma_len_0,
  output logic [DMA_DATA_W-1:0]   rdata_0,
  output logic                    ready_0,
  output logic                    error_0,
  input  logic                    valid_1,
  input  logic [AXI_ADDR_W-1:0]   address_1,
  input  logic [DMA_DATA_W-1:0]   wdata_1,
  input  logic [DMA_DATA_W/8-1:0] wstrb_1,
  input  logic [AXI_LEN_W-1:0]    dma_len_1,
  output logic [DMA_DATA_W-1:0]   rdata_1,
  output logic                    ready_1,
  output logic                    error_1,
  output logic                    m_valid,
  output logic [AXI_ADDR_W-1:0]   m_address,
  output logic [DMA_DATA_W-1:0]   m_wdata,
  output logic [DMA_DATA_W/8-1:0] m_wstrb,
  output logic [AXI_LEN_W-1:0]    m_dma_len,
  input  logic [DMA_DATA_W-1:0]   m_rdata,
  input  logic                    m_ready,
  input  logic                    m_dma_ready,
  input  logic                    m_error,
  output logic [1:0]              gnt,
  output logic                    timeout
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t               state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [AXI_LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic                 busy, sel, pick, beat, done;
`ifdef DMA_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q, timeout_d;
`endif
  assign busy = state_q == BUSY;
  assign sel  = gnt_q[1];
  // on a tie the port that did not win last time gets the bus
  assign pick = (valid_0 && valid_1) ? ~last_q : valid_1;
  assign beat = m_valid && m_ready;
  assign done = beat && (cnt_q == len_q);
  assign gnt  = gnt_q;
  always_comb begin
    m_valid   = busy && (sel ? valid_1 : valid_0);
    m_address = busy ? (sel ? address_1 : address_0) : '0;
    m_wdata   = busy ? (sel ? wdata_1 : wdata_0) : '0;
    m_wstrb   = busy ? (sel ? wstrb_1 : wstrb_0) : '0;
    m_dma_len = busy ? len_q : '0;
    ready_0   = busy && gnt_q[0] && m_ready;
    ready_1   = busy && gnt_q[1] && m_ready;
    error_0   = gnt_q[0] && m_error;
    error_1   = gnt_q[1] && m_error;
    rdata_0   = m_rdata;
    rdata_1   = m_rdata;
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef DMA_ARB_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (m_dma_ready && (valid_0 || valid_1)) begin
        state_d = BUSY;
        gnt_d   = pick ? 2'b10 : 2'b01;
        last_d  = pick;
        len_d   = pick ? dma_len_1 : dma_len_0;
        cnt_d   = '0;
`ifdef DMA_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      BUSY: begin
        // the last beat leaves the counter alone so all-ones lengths never wrap
        if (done) state_d = DRAIN;
        else if (beat) cnt_d = cnt_q + 1'b1;
`ifdef DMA_ARB_TIMEOUT_EN
        wd_d = beat ? '0 : wd_q + 1'b1;
        if (!beat && (&wd_q)) begin
          state_d   = DRAIN;
          timeout_d = 1'b1;
        end
`endif
      end
      DRAIN: if (m_dma_ready) begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= 1'b1;
      len_q     <= '0;
      cnt_q     <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
`ifdef DMA_ARB_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end
`ifdef DMA_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = |{TIMEOUT_W{1'b0}};
`endif
endmodule

// File: tb/tb_dma_axi_arb.sv
// tb_dma_axi_arb: directed self-checking bench for dma_axi_arb (default build).
module tb_dma_axi_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_0, valid_1, m_valid, m_ready, m_dma_ready, m_error, timeout;
  logic        ready_0, ready_1, error_0, error_1;
  logic [31:0] address_0, address_1, wdata_0, wdata_1, rdata_0, rdata_1;
  logic [31:0] m_address, m_wdata, m_rdata;
  logic [3:0]  wstrb_0, wstrb_1, m_wstrb;
  logic [7:0]  dma_len_0, dma_len_1, m_dma_len;
  logic [1:0]  gnt;
  logic        bad;
  int          passed = 0;
  int          fails = 0;
  int          total = 0;
  int          pulses;

  dma_axi_arb dut (
    .clk(clk), .rst(rst),
    .valid_0(valid_0), .address_0(address_0), .wdata_0(wdata_0), .wstrb_0(wstrb_0),
    .dma_len_0(dma_len_0), .rdata_0(rdata_0), .ready_0(ready_0), .error_0(error_0),
    .valid_1(valid_1), .address_1(address_1), .wdata_1(wdata_1), .wstrb_1(wstrb_1),
    .dma_len_1(dma_len_1), .rdata_1(rdata_1), .ready_1(ready_1), .error_1(error_1),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_dma_len(m_dma_len), .m_rdata(m_rdata), .m_ready(m_ready), .m_dma_ready(m_dma_ready),
    .m_error(m_error), .gnt(gnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    valid_0 = 0; valid_1 = 0; m_ready = 0; m_dma_ready = 0; m_error = 1;
    address_0 = 32'h1000; address_1 = 32'h2000;
    wdata_0 = 32'hA0A0_0001; wdata_1 = 32'hB0B0_0002;
    wstrb_0 = 4'hF; wstrb_1 = 4'h3; dma_len_0 = 0; dma_len_1 = 0;
    m_rdata = 32'h1234_5678;
    cyc;
    chk("rst_gnt", gnt, 0);
    chk("rst_ready0", ready_0, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_error0", error_0, 0);
    chk("rst_timeout", timeout, 0);
    rst = 0; m_error = 0;
    // single port 0 burst of four beats
    valid_0 = 1; dma_len_0 = 3; m_ready = 1; m_dma_ready = 1; #1;
    chk("a_pre_gnt", gnt, 0);
    chk("a_pre_mvalid", m_valid, 0);
    cyc;
    chk("a_gnt", gnt, 2'b01);
    chk("a_mvalid", m_valid, 1);
    chk("a_addr", m_address, 32'h1000);
    chk("a_wdata", m_wdata, 32'hA0A0_0001);
    chk("a_wstrb", m_wstrb, 4'hF);
    chk("a_len", m_dma_len, 3);
    chk("a_ready1", ready_1, 0);
    chk("a_rdata0", rdata_0, 32'h1234_5678);
    chk("a_rdata1", rdata_1, 32'h1234_5678);
    pulses = 0; m_dma_ready = 0;
    for (int i = 0; i < 4; i++) begin
      pulses += int'(ready_0);
      cyc;
    end
    chk("a_pulses", pulses, 4);
    chk("a_drain_mvalid", m_valid, 0);
    chk("a_drain_gnt", gnt, 2'b01);
    chk("a_drain_len", m_dma_len, 0);
    chk("a_drain_ready0", ready_0, 0);
    valid_0 = 0; m_error = 1; #1;
    chk("a_err0", error_0, 1);
    chk("a_err1", error_1, 0);
    cyc;
    chk("a_hold_gnt", gnt, 2'b01);
    m_dma_ready = 1;
    cyc;
    chk("a_idle_gnt", gnt, 0);
    chk("a_idle_err0", error_0, 0);
    m_error = 0;
    // reset in the middle of an eight-beat burst
    valid_0 = 1; dma_len_0 = 7;
    cyc; cyc; cyc;
    chk("b_pre_gnt", gnt, 2'b01);
    #2 rst = 1; #1;
    chk("b_rst_gnt", gnt, 0);
    chk("b_rst_ready0", ready_0, 0);
    chk("b_rst_mvalid", m_valid, 0);
    cyc;
    rst = 0; dma_len_0 = 1;
    cyc;
    chk("b_gnt", gnt, 2'b01);
    chk("b_len", m_dma_len, 1);
    chk("b_ready0", ready_0, 1);
    cyc;
    chk("b_beat2_mvalid", m_valid, 1);
    cyc;
    chk("b_drain_mvalid", m_valid, 0);
    chk("b_drain_gnt", gnt, 2'b01);
    valid_0 = 0;
    cyc;
    chk("b_idle_gnt", gnt, 0);
    // round-robin after a fresh reset
    rst = 1; #1; rst = 0; #1;
    valid_0 = 1; valid_1 = 1; dma_len_0 = 0; dma_len_1 = 0;
    cyc;
    chk("c_g1", gnt, 2'b01);
    cyc;
    chk("c_d1_gnt", gnt, 2'b01);
    chk("c_d1_mvalid", m_valid, 0);
    cyc;
    chk("c_i1", gnt, 0);
    cyc;
    chk("c_g2", gnt, 2'b10);
    chk("c_ready1", ready_1, 1);
    chk("c_ready0", ready_0, 0);
    chk("c_addr", m_address, 32'h2000);
    chk("c_wdata", m_wdata, 32'hB0B0_0002);
    chk("c_wstrb", m_wstrb, 4'h3);
    cyc; cyc; cyc;
    chk("c_g3", gnt, 2'b01);
    cyc;
    valid_0 = 0; valid_1 = 0;
    cyc;
    chk("c_end", gnt, 0);
    // port 1 pauses mid-burst while port 0 waits
    valid_1 = 1; dma_len_1 = 2;
    cyc;
    chk("d_gnt", gnt, 2'b10);
    cyc;
    valid_1 = 0; valid_0 = 1; bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc;
      bad = bad | ready_0 | m_valid | (gnt != 2'b10);
    end
    chk("d_hold", bad, 0);
    valid_1 = 1;
    cyc;
    chk("d_r0a", ready_0, 0);
    chk("d_gnt2", gnt, 2'b10);
    chk("d_ready1", ready_1, 1);
    cyc;
    chk("d_drain_gnt", gnt, 2'b10);
    chk("d_drain_mvalid", m_valid, 0);
    chk("d_drain_ready0", ready_0, 0);
    valid_1 = 0;
    cyc; cyc;
    chk("d_p0_gnt", gnt, 2'b01);
    chk("d_p0_ready0", ready_0, 1);
    cyc;
    valid_0 = 0;
    cyc;
    chk("d_end", gnt, 0);
    // downstream not ready holds off the grant
    m_dma_ready = 0; valid_0 = 1; dma_len_0 = 2; bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc;
      bad = bad | m_valid | (gnt != 2'b00);
    end
    chk("e_wait", bad, 0);
    m_dma_ready = 1;
    cyc;
    chk("e_gnt", gnt, 2'b01);
    m_ready = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc;
      bad = bad | timeout | ready_0 | !m_valid | (gnt != 2'b01);
    end
    chk("e_stall", bad, 0);
    chk("e_len", m_dma_len, 2);
    m_ready = 1;
    cyc; cyc;
    chk("e_busy", m_valid, 1);
    cyc;
    chk("e_drain_mvalid", m_valid, 0);
    chk("e_drain_gnt", gnt, 2'b01);
    valid_0 = 0;
    cyc;
    chk("e_end", gnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
